// File: rtl/sw_debounce_irq_ctrl.sv
// Avalon-MM switch/key controller: two-flop synchronizer, per-bit debounce,
// edge capture with write-1-to-clear, and a maskable registered interrupt.
module sw_debounce_irq_ctrl #(
  parameter int               WIDTH      = 4,
  parameter int               CNT_W      = 16,
  parameter logic [CNT_W-1:0] DB_DEFAULT = 16'd50000,
  parameter int               EDGE_TYPE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic             chipselect,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_MASK   = 2'd1,
    REG_EDGE   = 2'd2,
    REG_PERIOD = 2'd3
  } reg_e;

  logic [WIDTH-1:0] sync1, sync2, stable, mask, edge_cap;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic [WIDTH-1:0] upd, stable_nxt, edge_set, edge_clr;
  logic             wr_en;
  logic [31:0]      rd_mux;

  assign wr_en = chipselect & ~write_n;

  // NOTE: every always_comb output gets a default before any branch; a path
  // that skips an assignment would otherwise infer a latch.
  always_comb begin
    upd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == period) upd[i] = 1'b1;
        else                  cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
    end
    stable_nxt = (stable & ~upd) | (sync2 & upd);
  end

  // Edge direction is judged by the value stable is about to take.
  always_comb begin
    edge_set = '0;
    if (EDGE_TYPE == 0)      edge_set = upd & sync2;
    else if (EDGE_TYPE == 1) edge_set = upd & ~sync2;
    else                     edge_set = upd;
    edge_clr = '0;
    if (wr_en && reg_e'(address) == REG_EDGE) edge_clr = writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (reg_e'(address))
      REG_DATA:   rd_mux[WIDTH-1:0] = stable;
      REG_MASK:   rd_mux[WIDTH-1:0] = mask;
      REG_EDGE:   rd_mux[WIDTH-1:0] = edge_cap;
      REG_PERIOD: rd_mux[CNT_W-1:0] = period;
      default:    rd_mux = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      mask     <= '0;
      edge_cap <= '0;
      period   <= DB_DEFAULT;
      readdata <= '0;
      irq      <= 1'b0;
      // NOTE: the counter array is plain per-bit flops, not RAM, so it is
      // cleared explicitly like any other register.
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1  <= in_port;
      sync2  <= sync1;
      stable <= stable_nxt;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
      if (wr_en && reg_e'(address) == REG_MASK)   mask   <= writedata[WIDTH-1:0];
      if (wr_en && reg_e'(address) == REG_PERIOD) period <= writedata[CNT_W-1:0];
      // Set is OR-ed after the clear so a same-cycle capture survives.
      edge_cap <= (edge_cap & ~edge_clr) | edge_set;
      irq      <= |(edge_cap & mask);
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_sw_debounce_irq_ctrl.sv
// Bench for sw_debounce_irq_ctrl: rising-edge and any-edge instances checked every
// cycle against a history-window reference model, plus directed timing points.
module tb_sw_debounce_irq_ctrl;
  localparam int W = 4;

  logic          clk = 1'b0;
  logic          reset, write_n, chipselect;
  logic [1:0]    address;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd_a, rd_b;
  logic          irq_a, irq_b;
  int            total = 0;
  int            bad   = 0;

  always #5 clk = ~clk;

  sw_debounce_irq_ctrl #(.WIDTH(W), .CNT_W(16), .DB_DEFAULT(16'd50000), .EDGE_TYPE(0)) dut_a (
    .clk(clk), .reset(reset), .address(address), .write_n(write_n), .writedata(writedata),
    .chipselect(chipselect), .in_port(in_port), .readdata(rd_a), .irq(irq_a));

  sw_debounce_irq_ctrl #(.WIDTH(W), .CNT_W(16), .DB_DEFAULT(16'd50000), .EDGE_TYPE(2)) dut_b (
    .clk(clk), .reset(reset), .address(address), .write_n(write_n), .writedata(writedata),
    .chipselect(chipselect), .in_port(in_port), .readdata(rd_b), .irq(irq_b));

  // Reference model: the stable value flips once the synchronized input has
  // disagreed with it on the last period+1 samples since its previous flip.
  logic [W-1:0] m_s1, m_s2, m_stable, m_mask;
  logic [W-1:0] m_edge [2];
  logic         m_irq  [2];
  logic [31:0]  m_rd   [2];
  int           m_period;
  logic [W-1:0] hist [$];
  int           n_since [W];

  task automatic model_step();
    logic [W-1:0] upd, clr;
    logic [W-1:0] setv [2];
    bit           we, all_diff;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_mask = '0; m_period = 50000;
      for (int j = 0; j < 2; j++) begin
        m_edge[j] = '0; m_irq[j] = 1'b0; m_rd[j] = '0;
      end
      hist.delete();
      for (int i = 0; i < W; i++) n_since[i] = 0;
      return;
    end
    we = chipselect && !write_n;
    hist.push_back(m_s2);
    if (hist.size() > 64) void'(hist.pop_front());
    upd = '0;
    for (int i = 0; i < W; i++) begin
      n_since[i]++;
      if (n_since[i] >= m_period + 1) begin
        all_diff = 1'b1;
        for (int k = 0; k <= m_period; k++)
          if (hist[hist.size()-1-k][i] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) begin
          upd[i]     = 1'b1;
          n_since[i] = 0;
        end
      end
    end
    setv[0] = upd & m_s2;
    setv[1] = upd;
    clr = (we && address == 2'd2) ? writedata[W-1:0] : '0;
    for (int j = 0; j < 2; j++) begin
      m_irq[j] = |(m_edge[j] & m_mask);
      case (address)
        2'd0:    m_rd[j] = 32'(m_stable);
        2'd1:    m_rd[j] = 32'(m_mask);
        2'd2:    m_rd[j] = 32'(m_edge[j]);
        default: m_rd[j] = 32'(m_period);
      endcase
      m_edge[j] = (m_edge[j] & ~clr) | setv[j];
    end
    if (we && address == 2'd1) m_mask   = writedata[W-1:0];
    if (we && address == 2'd3) m_period = int'(writedata[15:0]);
    m_stable = (m_stable & ~upd) | (m_s2 & upd);
    m_s2 = m_s1;
    m_s1 = in_port;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("rd_a",  rd_a,         m_rd[0]);
    check("rd_b",  rd_b,         m_rd[1]);
    check("irq_a", 32'(irq_a),   32'(m_irq[0]));
    check("irq_b", 32'(irq_b),   32'(m_irq[1]));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    tick();
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    address = '0; writedata = '0; in_port = '0;
    ticks(2);
    reset = 1'b0;

    // Reset values across the map.
    rd(2'd0); check("rst_data", rd_a, 32'd0);
    rd(2'd1); check("rst_mask", rd_a, 32'd0);
    rd(2'd2); check("rst_edge", rd_b, 32'd0);
    rd(2'd3); check("rst_period", rd_a, 32'd50000);
    check("rst_irq", 32'(irq_a | irq_b), 32'd0);

    // Period 3: a held rise reaches stable at edge k+6, readdata one edge later.
    wr(2'd3, 32'd3);
    in_port = 4'b0001; address = 2'd0;
    ticks(6); check("lat_before", rd_a, 32'h0);
    tick();   check("lat_after",  rd_a, 32'h1);
    rd(2'd2); check("edge0_set",  rd_a, 32'h1);
    check("irq_unmasked", 32'(irq_a), 32'd0);

    // Bounce on bit 1 must not update; final hold updates after 6 edges.
    for (int p = 0; p < 4; p++) begin
      in_port[1] = ~p[0];
      ticks(2);
    end
    in_port[1] = 1'b1; address = 2'd0;
    ticks(6); check("bounce_before", rd_a, 32'h1);
    tick();   check("bounce_after",  rd_a, 32'h3);

    // Mask, irq rise, clear of an unrelated bit, then real clear.
    wr(2'd1, 32'h1); check("irq_lag", 32'(irq_a), 32'd0);
    tick();          check("irq_on",  32'(irq_a), 32'd1);
    wr(2'd2, 32'h2); tick(); check("irq_keep", 32'(irq_a), 32'd1);
    wr(2'd2, 32'h1); tick(); check("irq_off",  32'(irq_a), 32'd0);

    // Capture on bit 0 coinciding with a clear of bit 0: set wins.
    in_port = 4'b0010; ticks(10);
    wr(2'd2, 32'hF);
    in_port = 4'b0011;
    ticks(5);
    wr(2'd2, 32'h1);
    rd(2'd2);
    check("set_wins_a", rd_a, 32'h1);
    check("set_wins_b", rd_b, 32'h1);

    // Randomized segments: period changes only while inputs are settled.
    for (int seg = 0; seg < 8; seg++) begin
      ticks(20);
      wr(2'd3, 32'($urandom_range(0, 5)));
      for (int c = 0; c < 60; c++) begin
        int op;
        if ($urandom_range(0, 2) == 0) in_port[$urandom_range(0, W-1)] ^= 1'b1;
        op = $urandom_range(0, 9);
        address = 2'($urandom_range(0, 3));
        writedata = $urandom;
        chipselect = 1'b0; write_n = 1'b1;
        case (op)
          0: begin chipselect = 1'b1; write_n = 1'b0; address = 2'd1; end
          1: begin chipselect = 1'b1; write_n = 1'b0; address = 2'd2; end
          2: begin chipselect = 1'b1; write_n = 1'b0; address = 2'd0; end
          3: begin write_n = 1'b0; if (address == 2'd3) address = 2'd1; end
          default: ;
        endcase
        tick();
      end
      chipselect = 1'b0; write_n = 1'b1;
    end

    // Period 0: fall seen by the any-edge instance after three edges.
    wr(2'd3, 32'd0);
    in_port = 4'b1111; ticks(10);
    wr(2'd2, 32'hF);
    in_port = 4'b0000; address = 2'd0;
    ticks(3); check("p0_before", rd_a, 32'hF);
    tick();   check("p0_after",  rd_a, 32'h0);
    rd(2'd2);
    check("p0_edge_b", rd_b, 32'hF);
    check("p0_edge_a", rd_a, 32'h0);

    // Reset mid-count, then release with switches high.
    wr(2'd3, 32'd5);
    in_port = 4'b1111; ticks(3);
    reset = 1'b1; tick();
    check("mid_rst_rd",  rd_a, 32'd0);
    check("mid_rst_irq", 32'(irq_b), 32'd0);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a));
      check("post_rst_a", rd_a, (a == 3) ? 32'd50000 : 32'd0);
      check("post_rst_b", rd_b, (a == 3) ? 32'd50000 : 32'd0);
    end
    rd(2'd2); check("no_release_edge", rd_b, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
